tree_loader: RTL

- Upstream configuration sequencer for treeval.
- Accepts a node count from the host, then one record per node over a valid/ready stream, and buffers the records internally.
- Replays the records onto treeval's config/memory write ports in phase-major order: conf, parents, rewards, actions, weights.
- Pulses eval_start so treeval begins evaluation.

---
 rtl/tree_pkg.sv | 17 +
 rtl/tree_loader_if.sv | 36 +++
 rtl/tree_rec_buf.sv | 20 ++
 rtl/tree_loader.sv | 122 ++++++++++++
 4 files changed

// File: rtl/tree_pkg.sv
// tree_pkg: shared widths, action codes, loader FSM states and the node record type
package tree_pkg;
  localparam int W_ADDR = 10;
  localparam int W_N_DATA = 12;
  localparam int W_C_DATA = 10;
  localparam int W_ACTION = 3;
  localparam logic [W_ACTION-1:0] ACT_NO_PLAY = 3'b000;
  localparam logic [W_ACTION-1:0] ACT_PLAY = 3'b001;
  typedef enum logic [3:0] {IDLE, FILL, CONF, PAR, REW, ACT, WGT, KICK, DONE} loader_state_t;
  typedef struct packed {
    logic [W_ADDR-1:0] parent;
    logic [W_N_DATA-1:0] reward;
    logic [W_ACTION-1:0] action;
    logic [W_N_DATA-1:0] weight;
    logic leaf;
  } node_rec_t;
endpackage

// File: rtl/tree_loader_if.sv
// tree_loader_if: host config + record stream and treeval write bus of the loader
// slave modport = loader side (takes cfg/rec, drives strobes/status); master = host/treeval side
interface tree_loader_if;
  import tree_pkg::*;
  logic cfg_start;
  logic [W_C_DATA-1:0] cfg_nodes;
  logic rec_valid;
  logic rec_ready;
  logic [W_ADDR-1:0] rec_parent;
  logic [W_N_DATA-1:0] rec_reward;
  logic [W_ACTION-1:0] rec_action;
  logic [W_N_DATA-1:0] rec_weight;
  logic rec_leaf;
  logic conf_nodes;
  logic [W_C_DATA-1:0] conf_data;
  logic mem_par;
  logic mem_rew;
  logic mem_act;
  logic mem_weight;
  logic [W_ADDR-1:0] mem_addr;
  logic [W_N_DATA-1:0] mem_data;
  logic eval_start;
  logic busy;
  logic done;
  logic err;
  modport slave (
    input cfg_start, cfg_nodes, rec_valid, rec_parent, rec_reward, rec_action, rec_weight, rec_leaf,
    output rec_ready, conf_nodes, conf_data, mem_par, mem_rew, mem_act, mem_weight, mem_addr, mem_data,
    output eval_start, busy, done, err
  );
  modport master (
    output cfg_start, cfg_nodes, rec_valid, rec_parent, rec_reward, rec_action, rec_weight, rec_leaf,
    input rec_ready, conf_nodes, conf_data, mem_par, mem_rew, mem_act, mem_weight, mem_addr, mem_data,
    input eval_start, busy, done, err
  );
endinterface

// File: rtl/tree_rec_buf.sv
// tree_rec_buf: 2**AW x node_rec_t record store, one write port, one registered read port, no reset
// ports: clk; we/waddr/wdata write; raddr in, rdata = mem[raddr] one cycle later
module tree_rec_buf
  import tree_pkg::*;
#(
  parameter int AW = 6
) (
  input  logic clk,
  input  logic we,
  input  logic [AW-1:0] waddr,
  input  node_rec_t wdata,
  input  logic [AW-1:0] raddr,
  output node_rec_t rdata
);
  node_rec_t mem [2**AW];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/tree_loader.sv
// tree_loader: buffers N node records, then replays them phase-major onto treeval write ports
// ports: clk, rst (async, active-low); b = tree_loader_if.slave (cfg, record stream, treeval bus, status)
module tree_loader
  import tree_pkg::*;
#(
  parameter int MAX_NODES = 64
) (
  input logic clk,
  input logic rst,
  tree_loader_if.slave b
);
  localparam int PW = W_ADDR + 1;
  localparam int AW = MAX_NODES > 1 ? $clog2(MAX_NODES) : 1;
  loader_state_t state, nxt_state;
  logic [PW-1:0] ptr, nxt_ptr, n, from, cand;
  logic [MAX_NODES-1:0] leafs;
  logic hit, found, hs, start_ok, over, emit;
  node_rec_t rd;
  assign hs = b.rec_valid & b.rec_ready & (state == FILL);
  assign start_ok = b.cfg_start & (state == IDLE || state == DONE);
  assign over = {1'b0, b.cfg_nodes} > PW'(MAX_NODES);
  assign emit = state inside {PAR, REW, ACT, WGT};
  // read address follows the next pointer so rd holds buffer[ptr] while in an emit state
  tree_rec_buf #(.AW(AW)) u_buf (
    .clk(clk),
    .we(hs),
    .waddr(ptr[AW-1:0]),
    .wdata('{b.rec_parent, b.rec_reward, b.rec_action, b.rec_weight, b.rec_leaf}),
    .raddr(nxt_ptr[AW-1:0]),
    .rdata(rd)
  );
  // replay: find the next qualifying (phase, index), skipping empty phases and non-leaves in zero cycles
  always_comb begin
    nxt_state = state;
    nxt_ptr = ptr;
    hit = 1'b0;
    from = '0;
    cand = '0;
    found = 1'b0;
    case (state)
      IDLE, DONE: if (b.cfg_start) begin
        nxt_state = b.cfg_nodes == '0 ? DONE : FILL;
        nxt_ptr = '0;
      end
      FILL: if (hs) begin
        nxt_ptr = ptr + 1'b1;
        nxt_state = ptr == n - 1'b1 ? CONF : FILL;
      end
      KICK: nxt_state = DONE;
      default: begin
        nxt_state = KICK;
        for (int p = int'(PAR); p <= int'(WGT); p++) begin
          if (!hit && p >= int'(state)) begin
            from = p == int'(state) ? ptr + 1'b1 : '0;
            cand = from == '0 ? PW'(1) : from;
            found = cand < n;
            if (p == int'(REW)) begin
              found = 1'b0;
              for (int i = MAX_NODES - 1; i >= 0; i--)
                if (PW'(i) >= from && PW'(i) < n && leafs[i]) begin
                  found = 1'b1;
                  cand = PW'(i);
                end
            end
            if (found) begin
              hit = 1'b1;
              nxt_state = loader_state_t'(p[3:0]);
              nxt_ptr = cand;
            end
          end
        end
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      ptr <= '0;
      n <= '0;
      leafs <= '0;
      b.err <= 1'b0;
      b.rec_ready <= 1'b0;
      b.busy <= 1'b0;
      b.done <= 1'b0;
      b.conf_nodes <= 1'b0;
      b.conf_data <= '0;
      b.mem_par <= 1'b0;
      b.mem_rew <= 1'b0;
      b.mem_act <= 1'b0;
      b.mem_weight <= 1'b0;
      b.mem_addr <= '0;
      b.mem_data <= '0;
      b.eval_start <= 1'b0;
    end else begin
      state <= nxt_state;
      ptr <= nxt_ptr;
      if (start_ok) begin
        n <= over ? PW'(MAX_NODES) : {1'b0, b.cfg_nodes};
        b.err <= b.cfg_nodes == '0 || over;
      end
      if (hs) begin
        leafs[ptr[AW-1:0]] <= b.rec_leaf;
        if (ptr != '0 && {1'b0, b.rec_parent} >= ptr) b.err <= 1'b1;
      end
      b.rec_ready <= nxt_state == FILL;
      b.busy <= !(nxt_state inside {IDLE, DONE});
      b.done <= nxt_state == DONE;
      b.conf_nodes <= state == CONF;
      b.conf_data <= state == CONF ? n[W_C_DATA-1:0] : '0;
      b.mem_par <= state == PAR;
      b.mem_rew <= state == REW && rd.leaf;
      b.mem_act <= state == ACT;
      b.mem_weight <= state == WGT;
      b.mem_addr <= emit ? ptr[W_ADDR-1:0] : '0;
      b.mem_data <= state == PAR ? W_N_DATA'(rd.parent) :
                    state == REW ? rd.reward :
                    state == ACT ? W_N_DATA'(rd.action) :
                    state == WGT ? rd.weight : '0;
      b.eval_start <= state == KICK;
    end
  end
endmodule
